servant_timer_mc: RTL and testbench

Multi-channel, parametrised Wishbone timer for the SERV SoC peripheral bus. Provides one free-running WIDTH-bit counter with a programmable prescaler and CHANNELS independent compare channels, each in one-shot or auto-reload (periodic) mode. Per-channel pending and enable bits are combined into one level interrupt to the core. Software loads the counter, compare and period registers through a word-addressed register file.

---
 rtl/servant_timer_mc.sv | 184 ++++++++++++++++++
 tb/tb_servant_timer_mc.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_timer_mc.sv
// servant_timer_mc: Wishbone timer with prescaler, one free-running counter
// and CHANNELS compare channels (one-shot or periodic) sharing one level IRQ.
module servant_timer_mc #(
    parameter int WIDTH      = 32,
    parameter int CHANNELS   = 2,
    parameter int PRESCALE_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat,
    output logic        o_irq
);

    logic                  r_en;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [WIDTH-1:0]      r_count;
    logic [CHANNELS-1:0]   r_pend;
    logic [CHANNELS-1:0]   r_irqen;
    logic [CHANNELS-1:0]   r_arm;
    logic [CHANNELS-1:0]   r_periodic;
    logic [WIDTH-1:0]      r_cmp    [CHANNELS];
    logic [WIDTH-1:0]      r_period [CHANNELS];
    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_irq;

    logic                  w_commit;
    logic                  w_wr;
    logic                  w_wrCtrl;
    logic                  w_wrPresc;
    logic                  w_wrCount;
    logic                  w_wrStatus;
    logic                  w_wrIrqen;
    logic                  w_tick;
    logic [WIDTH-1:0]      w_next;
    logic [CHANNELS-1:0]   w_chSel;
    logic [CHANNELS-1:0]   w_wrCmp;
    logic [CHANNELS-1:0]   w_wrPeriod;
    logic [CHANNELS-1:0]   w_wrCctrl;
    logic [CHANNELS-1:0]   w_match;
    logic [31:0]           w_rdData;
    logic                  w_unusedBits;

    // An access commits on the edge where ack rises, so a held cyc only
    // commits on alternate cycles.
    assign w_commit   = i_wb_cyc & ~r_ack;
    assign w_wr       = w_commit & i_wb_we;
    assign w_wrCtrl   = w_wr && (i_wb_adr == 6'd0);
    assign w_wrPresc  = w_wr && (i_wb_adr == 6'd1);
    assign w_wrCount  = w_wr && (i_wb_adr == 6'd2);
    assign w_wrStatus = w_wr && (i_wb_adr == 6'd3);
    assign w_wrIrqen  = w_wr && (i_wb_adr == 6'd4);

    assign w_tick = r_en && (r_pcnt == r_presc);
    assign w_next = r_count + WIDTH'(1);

    // Write data bits above the register widths are deliberately dropped.
    assign w_unusedBits = ^i_wb_dat;

    // Channel decode and match detection; a COUNT write suppresses matching.
    always_comb begin
        w_chSel    = '0;
        w_wrCmp    = '0;
        w_wrPeriod = '0;
        w_wrCctrl  = '0;
        w_match    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_chSel[c]    = (i_wb_adr[5:2] == 4'(c + 2));
            w_wrCmp[c]    = w_wr && w_chSel[c] && (i_wb_adr[1:0] == 2'd0);
            w_wrPeriod[c] = w_wr && w_chSel[c] && (i_wb_adr[1:0] == 2'd1);
            w_wrCctrl[c]  = w_wr && w_chSel[c] && (i_wb_adr[1:0] == 2'd2);
            w_match[c]    = w_tick && !w_wrCount && r_arm[c] && (w_next == r_cmp[c]);
        end
    end

    // Read multiplexer; unmapped addresses and unused bits read as zero.
    always_comb begin
        w_rdData = '0;
        case (i_wb_adr)
            6'd0:    w_rdData = {31'b0, r_en};
            6'd1:    w_rdData = 32'(r_presc);
            6'd2:    w_rdData = 32'(r_count);
            6'd3:    w_rdData = 32'(r_pend);
            6'd4:    w_rdData = 32'(r_irqen);
            default: ;
        endcase
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_chSel[c]) begin
                case (i_wb_adr[1:0])
                    2'd0:    w_rdData = 32'(r_cmp[c]);
                    2'd1:    w_rdData = 32'(r_period[c]);
                    2'd2:    w_rdData = {30'b0, r_periodic[c], r_arm[c]};
                    default: ;
                endcase
            end
        end
    end

    // Global control registers written from the bus.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en    <= 1'b0;
            r_presc <= '0;
            r_irqen <= '0;
        end else begin
            if (w_wrCtrl)  r_en    <= i_wb_dat[0];
            if (w_wrPresc) r_presc <= i_wb_dat[PRESCALE_W-1:0];
            if (w_wrIrqen) r_irqen <= i_wb_dat[CHANNELS-1:0];
        end
    end

    // Prescaler and counter; a bus load of COUNT wins and restarts the prescaler.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt  <= '0;
            r_count <= '0;
        end else if (w_wrCount) begin
            r_pcnt  <= '0;
            r_count <= i_wb_dat[WIDTH-1:0];
        end else begin
            if (r_en)   r_pcnt  <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);
            if (w_tick) r_count <= w_next;
        end
    end

    // Per-channel compare state: bus writes beat reload/disarm, a match beats W1C.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arm      <= '0;
            r_periodic <= '0;
            r_pend     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_cmp[c]    <= '0;
                r_period[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wrCmp[c])
                    r_cmp[c] <= i_wb_dat[WIDTH-1:0];
                else if (w_match[c] && r_periodic[c])
                    r_cmp[c] <= r_cmp[c] + r_period[c];

                if (w_wrPeriod[c])
                    r_period[c] <= i_wb_dat[WIDTH-1:0];

                if (w_wrCctrl[c]) begin
                    r_arm[c]      <= i_wb_dat[0];
                    r_periodic[c] <= i_wb_dat[1];
                end else if (w_match[c] && !r_periodic[c]) begin
                    r_arm[c] <= 1'b0;
                end

                if (w_match[c])
                    r_pend[c] <= 1'b1;
                else if (w_wrStatus && i_wb_dat[c])
                    r_pend[c] <= 1'b0;
            end
        end
    end

    // Bus handshake, registered read data and registered interrupt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_commit;
            if (w_commit) r_dat <= w_rdData;
            r_irq <= |(r_pend & r_irqen);
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_dat;
    assign o_irq    = r_irq;

endmodule

// File: tb/tb_servant_timer_mc.sv
// tb_servant_timer_mc: directed bench for servant_timer_mc at WIDTH=8,
// CHANNELS=2; expected values are hand-computed from the register semantics.
module tb_servant_timer_mc;

    localparam logic [5:0] A_CTRL   = 6'd0;
    localparam logic [5:0] A_PRESC  = 6'd1;
    localparam logic [5:0] A_COUNT  = 6'd2;
    localparam logic [5:0] A_STATUS = 6'd3;
    localparam logic [5:0] A_IRQEN  = 6'd4;
    localparam logic [5:0] A_CMP0   = 6'd8;
    localparam logic [5:0] A_CCTRL0 = 6'd10;
    localparam logic [5:0] A_CMP1   = 6'd12;
    localparam logic [5:0] A_PER1   = 6'd13;
    localparam logic [5:0] A_CCTRL1 = 6'd14;

    logic        i_clk;
    logic        i_rst;
    logic [5:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat;
    logic        o_irq;

    int          assertCnt;
    int          failCnt;
    int          cycleCnt;
    logic        irqAtAck;

    servant_timer_mc #(.WIDTH(8), .CHANNELS(2), .PRESCALE_W(16)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_ack (o_wb_ack),
        .o_wb_dat (o_wb_dat),
        .o_irq    (o_irq)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Cycle stamp used to measure distances between interrupt edges.
    always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one access; returns one cycle after the ack so ack is low again.
    task automatic busWrite(input logic [5:0] adr, input logic [31:0] dat);
        int n;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge i_clk); #1;
            n++;
        end while (!o_wb_ack && n < 4);
        if (!o_wb_ack) checkOutput("writeAckTimeout", 32'(o_wb_ack), 32'd1);
        irqAtAck = o_irq;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic busRead(input logic [5:0] adr, output logic [31:0] dat);
        int n;
        i_wb_adr = adr;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge i_clk); #1;
            n++;
        end while (!o_wb_ack && n < 4);
        if (!o_wb_ack) checkOutput("readAckTimeout", 32'(o_wb_ack), 32'd1);
        dat = o_wb_dat;
        i_wb_cyc = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic waitIrq(input int limit, output int n);
        n = 0;
        while (!o_irq && n < limit) begin
            @(posedge i_clk); #1;
            n++;
        end
    endtask

    task automatic readCheck(input string tag, input logic [5:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        busRead(adr, rd);
        checkOutput(tag, rd, exp);
    endtask

    initial begin
        int n;
        int t1, t2, t3;
        logic [5:0] regList [11];
        assertCnt = 0;
        failCnt   = 0;
        cycleCnt  = 0;
        irqAtAck  = 1'b0;
        i_rst     = 1'b1;
        i_wb_adr  = '0;
        i_wb_dat  = '0;
        i_wb_we   = 1'b0;
        i_wb_cyc  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rstAck", 32'(o_wb_ack), 32'd0);
        checkOutput("rstIrq", 32'(o_irq), 32'd0);
        checkOutput("rstDat", o_wb_dat, 32'd0);
        i_rst = 1'b0;
        readCheck("rstCount", A_COUNT, 32'd0);
        readCheck("rstStatus", A_STATUS, 32'd0);

        // Prescale P=3: count after m cycles of EN is m/4, so 5 after 20.
        busWrite(A_PRESC, 32'd3);
        busWrite(A_CTRL, 32'd1);
        repeat (19) @(posedge i_clk);
        #1;
        readCheck("presc3Count", A_COUNT, 32'd5);

        // P=0: one increment per cycle, two reads two cycles apart.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_PRESC, 32'd0);
        busWrite(A_CTRL, 32'd1);
        readCheck("presc0CountA", A_COUNT, 32'd1);
        readCheck("presc0CountB", A_COUNT, 32'd3);

        // One-shot on channel 0 at count 10.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_CMP0, 32'd10);
        busWrite(A_CCTRL0, 32'd1);
        busWrite(A_IRQEN, 32'd1);
        busWrite(A_CTRL, 32'd1);
        checkOutput("oneShotIrqIdle", 32'(o_irq), 32'd0);
        waitIrq(40, n);
        checkOutput("oneShotIrqDelay", 32'(n), 32'd10);
        readCheck("oneShotStatus", A_STATUS, 32'd1);
        readCheck("oneShotDisarm", A_CCTRL0, 32'd0);
        busWrite(A_STATUS, 32'd1);
        checkOutput("w1cIrqAtAck", 32'(irqAtAck), 32'd1);
        checkOutput("w1cIrqAfter", 32'(o_irq), 32'd0);
        repeat (300) @(posedge i_clk);
        #1;
        readCheck("oneShotNoRefire", A_STATUS, 32'd0);

        // Periodic channel 1: matches at 100, 150, 200.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_STATUS, 32'd3);
        busWrite(A_IRQEN, 32'd2);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_CMP1, 32'd100);
        busWrite(A_PER1, 32'd50);
        busWrite(A_CCTRL1, 32'd3);
        busWrite(A_CTRL, 32'd1);
        waitIrq(200, n);
        t1 = cycleCnt;
        checkOutput("perFirstDelay", 32'(n), 32'd100);
        readCheck("perStatus", A_STATUS, 32'd2);
        busWrite(A_STATUS, 32'd2);
        checkOutput("perClear1", 32'(o_irq), 32'd0);
        waitIrq(100, n);
        t2 = cycleCnt;
        checkOutput("perGap1", 32'(t2 - t1), 32'd50);
        busWrite(A_STATUS, 32'd2);
        checkOutput("perClear2", 32'(o_irq), 32'd0);
        waitIrq(100, n);
        t3 = cycleCnt;
        checkOutput("perGap2", 32'(t3 - t2), 32'd50);
        readCheck("perCmpNext", A_CMP1, 32'd250);
        readCheck("perStillArmed", A_CCTRL1, 32'd3);

        // Wrap one-shot: 250 -> 255 -> 0 -> 4 takes 10 ticks.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_CCTRL1, 32'd0);
        busWrite(A_STATUS, 32'd3);
        busWrite(A_IRQEN, 32'd1);
        busWrite(A_COUNT, 32'd250);
        busWrite(A_CMP0, 32'd4);
        busWrite(A_CCTRL0, 32'd1);
        busWrite(A_CTRL, 32'd1);
        waitIrq(40, n);
        checkOutput("wrapDelay", 32'(n), 32'd10);
        readCheck("wrapStatus", A_STATUS, 32'd1);

        // Wrap periodic: 250 + 10 mod 256 = 4.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_STATUS, 32'd3);
        busWrite(A_IRQEN, 32'd2);
        busWrite(A_COUNT, 32'd240);
        busWrite(A_CMP1, 32'd250);
        busWrite(A_PER1, 32'd10);
        busWrite(A_CCTRL1, 32'd3);
        busWrite(A_CTRL, 32'd1);
        waitIrq(40, n);
        checkOutput("wrapPerDelay", 32'(n), 32'd10);
        readCheck("wrapPerCmp", A_CMP1, 32'd4);
        busWrite(A_CCTRL1, 32'd0);

        // Collision: COUNT=7 written on the edge the count would reach CMP_0=7.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_STATUS, 32'd3);
        busWrite(A_IRQEN, 32'd1);
        busWrite(A_CMP0, 32'd7);
        busWrite(A_CCTRL0, 32'd1);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_CTRL, 32'd1);
        repeat (5) @(posedge i_clk);
        #1;
        busWrite(A_COUNT, 32'd7);
        readCheck("collCountLoad", A_COUNT, 32'd8);
        readCheck("collNoMatch", A_STATUS, 32'd0);
        readCheck("collStillArmed", A_CCTRL0, 32'd1);

        // Collision: W1C of pending_0 on its own match edge.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_CTRL, 32'd1);
        repeat (5) @(posedge i_clk);
        #1;
        busWrite(A_STATUS, 32'd1);
        readCheck("collSetWins", A_STATUS, 32'd1);
        readCheck("collDisarm", A_CCTRL0, 32'd0);

        // Ack pattern with cyc held for a read.
        busWrite(A_CTRL, 32'd0);
        i_wb_adr = A_CTRL;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        checkOutput("ackHold0", 32'(o_wb_ack), 32'd0);
        for (int k = 1; k < 6; k++) begin
            @(posedge i_clk); #1;
            checkOutput($sformatf("ackHold%0d", k), 32'(o_wb_ack), 32'(k % 2));
        end
        i_wb_cyc = 1'b0;
        @(posedge i_clk); #1;

        // Held write of COUNT=0 commits on alternate edges only.
        busWrite(A_CTRL, 32'd1);
        i_wb_adr = A_COUNT;
        i_wb_dat = 32'd0;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        i_wb_we = 1'b0;
        readCheck("heldWriteOnce", A_COUNT, 32'd1);

        // Unmapped addresses and unused bits.
        busWrite(A_CTRL, 32'd0);
        busWrite(A_PRESC, 32'hFFFF_FFFF);
        readCheck("prescBits", A_PRESC, 32'h0000_FFFF);
        busWrite(A_CMP0, 32'hFFFF_FFFF);
        readCheck("cmpBits", A_CMP0, 32'h0000_00FF);
        busWrite(6'd11, 32'hFFFF_FFFF);
        readCheck("adr11", 6'd11, 32'd0);
        busWrite(6'd16, 32'hFFFF_FFFF);
        readCheck("noChannel2", 6'd16, 32'd0);
        readCheck("adr5", 6'd5, 32'd0);
        busWrite(A_IRQEN, 32'hFFFF_FFFF);
        readCheck("irqenBits", A_IRQEN, 32'd3);
        busWrite(A_PRESC, 32'd0);

        // Reset while ack is high, with the interrupt asserted.
        busWrite(A_STATUS, 32'd3);
        busWrite(A_IRQEN, 32'd1);
        busWrite(A_COUNT, 32'd0);
        busWrite(A_CMP0, 32'd3);
        busWrite(A_CCTRL0, 32'd1);
        busWrite(A_CTRL, 32'd1);
        waitIrq(20, n);
        checkOutput("preRstIrq", 32'(o_irq), 32'd1);
        i_wb_adr = A_COUNT;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        @(posedge i_clk); #1;
        checkOutput("preRstAck", 32'(o_wb_ack), 32'd1);
        i_rst    = 1'b1;
        i_wb_cyc = 1'b0;
        @(posedge i_clk); #1;
        checkOutput("midRstAck", 32'(o_wb_ack), 32'd0);
        checkOutput("midRstIrq", 32'(o_irq), 32'd0);
        checkOutput("midRstDat", o_wb_dat, 32'd0);
        i_rst = 1'b0;
        regList = '{A_CTRL, A_PRESC, A_COUNT, A_STATUS, A_IRQEN, A_CMP0, 6'd9,
                    A_CCTRL0, A_CMP1, A_PER1, A_CCTRL1};
        foreach (regList[i])
            readCheck($sformatf("rstReg%0d", regList[i]), regList[i], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
